// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave fronting a bank of NUM_REGS 32-bit read/write registers.
// The write path buffers AW and W independently; the read path runs in parallel.
`timescale 1ns/1ps
module axi_lite_reg_slave #(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];
  logic             aw_full_q, aw_full_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             aw_err_q, aw_err_d;
  logic             w_full_q, w_full_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             ar_err;
  logic             unused_inputs;

  assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
  assign ar_err        = |araddr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    regs_d    = regs_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[2 +: IDX_W];
      aw_err_d  = |awaddr[ADDR_WIDTH-1:IDX_W+2];
    end
    if (wvalid && wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end

    // Both halves were buffered on an earlier edge, so commit now.
    if (aw_full_q && w_full_q) begin
      if (!aw_err_q) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) regs_d[aw_idx_q][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
      bvalid_d  = 1'b1;
      bresp_d   = aw_err_q ? 2'b10 : 2'b00;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end

    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;

    // Reads sample regs_q, so a same-edge commit is not yet visible.
    if (arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_err ? 32'h0 : regs_q[araddr[2 +: IDX_W]];
      rresp_d  = ar_err ? 2'b10 : 2'b00;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end

    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_full_q  <= 1'b0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed scenarios with literal
// expectations plus randomized concurrent traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_lite_reg_slave;

   localparam int NUM_REGS   = 16;
   localparam int ADDR_WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
   logic [3:0] wstrb = '0;
   logic [2:0] awprot = '0, arprot = '0;
   logic awready, wready, bvalid, arready, rvalid;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;

   int checkCount = 0;
   int errorCount = 0;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   axi_lite_reg_slave #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model: register array plus queues of owed responses
   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   logic [31:0] mem [NUM_REGS];
   rsp_t        rq[$];
   logic [1:0]  bq[$];
   bit          mAwFull, mWFull, mCommitNext;
   logic [31:0] mAwAddr, mWData;
   logic [3:0]  mWStrb;
   bit          prevRst = 1'b0;
   bit          prevBvalid, prevBready, prevRvalid, prevRready;
   logic [1:0]  prevBresp, prevRresp;
   logic [31:0] prevRdata;

   function automatic bit outOfRange(input logic [31:0] a);
      return a >= 32'(NUM_REGS * 4);
   endfunction

   function automatic int regIndex(input logic [31:0] a);
      return int'((a >> 2) % NUM_REGS);
   endfunction

   // Sample at the falling edge: outputs are settled and inputs for the next
   // rising edge are already driven, so handshakes can be predicted here
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] = 32'h0;
            rq.delete();
            bq.delete();
            mAwFull = 0; mWFull = 0; mCommitNext = 0;
            prevBvalid = 0; prevRvalid = 0; prevBready = 0; prevRready = 0;
            checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
            checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
            checkOutput("reset_bresp", 32'(bresp), 32'd0);
            checkOutput("reset_rresp", 32'(rresp), 32'd0);
            checkOutput("reset_rdata", rdata, 32'd0);
            checkOutput("reset_readies", 32'({awready, wready, arready}), 32'd0);
         end else begin
            bit awHs, wHs, arHs;
            checkOutput("awready", 32'(awready), 32'(prevRst && !mAwFull && bq.size() == 0));
            checkOutput("wready", 32'(wready), 32'(prevRst && !mWFull && bq.size() == 0));
            checkOutput("arready", 32'(arready), 32'(prevRst && rq.size() == 0));
            checkOutput("bvalid", 32'(bvalid), 32'(bq.size() != 0));
            if (bq.size() != 0) checkOutput("bresp", 32'(bresp), 32'(bq[0]));
            checkOutput("rvalid", 32'(rvalid), 32'(rq.size() != 0));
            if (rq.size() != 0) begin
               checkOutput("rdata", rdata, rq[0].data);
               checkOutput("rresp", 32'(rresp), 32'(rq[0].resp));
            end
            if (prevBvalid && !prevBready) begin
               checkOutput("b_stable_valid", 32'(bvalid), 32'd1);
               checkOutput("b_stable_resp", 32'(bresp), 32'(prevBresp));
            end
            if (prevRvalid && !prevRready) begin
               checkOutput("r_stable_valid", 32'(rvalid), 32'd1);
               checkOutput("r_stable_data", rdata, prevRdata);
               checkOutput("r_stable_resp", 32'(rresp), 32'(prevRresp));
            end

            awHs = awvalid && awready;
            wHs  = wvalid && wready;
            arHs = arvalid && arready;
            if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
            if (bvalid && bready && bq.size() != 0) void'(bq.pop_front());
            if (arHs) begin
               rsp_t r;
               r.data = outOfRange(araddr) ? 32'h0 : mem[regIndex(araddr)];
               r.resp = outOfRange(araddr) ? 2'b10 : 2'b00;
               rq.push_back(r);
            end
            if (mCommitNext) begin
               if (!outOfRange(mAwAddr)) begin
                  for (int b = 0; b < 4; b++)
                     if (mWStrb[b]) mem[regIndex(mAwAddr)][8*b +: 8] = mWData[8*b +: 8];
               end
               bq.push_back(outOfRange(mAwAddr) ? 2'b10 : 2'b00);
               mAwFull = 0; mWFull = 0; mCommitNext = 0;
            end
            if (awHs) begin mAwFull = 1; mAwAddr = awaddr; end
            if (wHs) begin mWFull = 1; mWData = wdata; mWStrb = wstrb; end
            if (mAwFull && mWFull) mCommitNext = 1;

            prevBvalid = bvalid; prevBready = bready; prevBresp = bresp;
            prevRvalid = rvalid; prevRready = rready; prevRdata = rdata; prevRresp = rresp;
         end
         prevRst = rst;
      end
   end

   // Channel drivers: start just after a rising edge, leave just after one
   task automatic sendAw(input logic [31:0] addr);
      bit ok = 0;
      awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (awready) begin ok = 1; break; end
      end
      if (!ok) checkOutput("aw_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
      bit ok = 0;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wready) begin ok = 1; break; end
      end
      if (!ok) checkOutput("w_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      wvalid = 1'b0;
   endtask

   // bDelay < 0 leaves the response pending (bready low) on return
   task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDelay, input int wDelay, input int bDelay,
                           output logic [1:0] resp, output int lat);
      bit ok = 0;
      fork
         begin repeat (awDelay) begin @(posedge clk); #1; end sendAw(addr); end
         begin repeat (wDelay) begin @(posedge clk); #1; end sendW(data, strb); end
      join
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bvalid) begin ok = 1; break; end
         lat++;
      end
      resp = bresp;
      if (!ok) checkOutput("b_timeout", 32'd0, 32'd1);
      if (bDelay >= 0) begin
         repeat (bDelay + 1) @(posedge clk);
         #1 bready = 1'b1;
         @(posedge clk); #1;
         bready = 1'b0;
      end
   endtask

   task automatic readTxn(input logic [31:0] addr, input int rDelay,
                          output logic [31:0] data, output logic [1:0] resp);
      bit ok = 0;
      araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (arready) begin ok = 1; break; end
      end
      if (!ok) checkOutput("ar_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rvalid) begin ok = 1; break; end
      end
      if (!ok) checkOutput("r_timeout", 32'd0, 32'd1);
      data = rdata; resp = rresp;
      repeat (rDelay + 1) @(posedge clk);
      #1 rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   function automatic logic [31:0] randAddr();
      if ($urandom_range(0, 9) == 0) return 32'h8000_0000 | ($urandom & 32'hFC);
      return 32'($urandom_range(0, 'h47));
   endfunction

   // Randomized concurrent writers and readers; the model checks every cycle
   task automatic applyStimulus(input int count);
      fork
         begin
            logic [1:0] r; int l;
            for (int i = 0; i < count; i++) begin
               writeTxn(randAddr(), $urandom, 4'($urandom), $urandom_range(0, 2),
                        $urandom_range(0, 2), $urandom_range(0, 2), r, l);
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
         begin
            logic [31:0] d; logic [1:0] r;
            for (int i = 0; i < count; i++) begin
               readTxn(randAddr(), $urandom_range(0, 2), d, r);
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
         end
      join
   endtask

   // Directed scenarios with hand-computed literal expectations
   initial begin
      logic [31:0] d;
      logic [1:0] r;
      int lat;
      logic [31:0] expRegs [NUM_REGS];

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("readies_after_first_edge", 32'({awready, wready, arready}), 32'h7);
      readTxn(32'h0, 0, d, r);
      checkOutput("reset_read_data", d, 32'h0000_0000);
      checkOutput("reset_read_resp", 32'(r), 32'd0);

      writeTxn(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r, lat);
      checkOutput("full_write_resp", 32'(r), 32'd0);
      checkOutput("full_write_latency", 32'(lat), 32'd1);
      readTxn(32'h4, 0, d, r);
      checkOutput("full_read_data", d, 32'hDEAD_BEEF);
      checkOutput("full_read_resp", 32'(r), 32'd0);

      writeTxn(32'h8, 32'h1122_3344, 4'hF, 0, 0, 0, r, lat);
      writeTxn(32'h8, 32'hAABB_CCDD, 4'b0101, 0, 0, 1, r, lat);
      readTxn(32'h8, 1, d, r);
      checkOutput("strobe_read_data", d, 32'h11BB_33DD);

      writeTxn(32'hC, 32'h0000_0055, 4'hF, 2, 0, 3, r, lat);
      checkOutput("ordered_write_resp", 32'(r), 32'd0);
      readTxn(32'hC, 0, d, r);
      checkOutput("ordered_read_data", d, 32'h0000_0055);

      writeTxn(32'h40, 32'h1234_5678, 4'hF, 0, 1, 0, r, lat);
      checkOutput("oor_write_resp", 32'(r), 32'd2);
      readTxn(32'h40, 0, d, r);
      checkOutput("oor_read_data", d, 32'h0);
      checkOutput("oor_read_resp", 32'(r), 32'd2);
      for (int i = 0; i < NUM_REGS; i++) expRegs[i] = 32'h0;
      expRegs[1] = 32'hDEAD_BEEF;
      expRegs[2] = 32'h11BB_33DD;
      expRegs[3] = 32'h0000_0055;
      for (int i = 0; i < NUM_REGS; i++) begin
         readTxn(32'(i * 4), 0, d, r);
         checkOutput($sformatf("unchanged_reg%0d", i), d, expRegs[i]);
      end

      fork
         writeTxn(32'h4, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r, lat);
         begin
            logic [31:0] dOld; logic [1:0] rOld;
            @(posedge clk); #1;
            readTxn(32'h4, 0, dOld, rOld);
            checkOutput("same_edge_read_old", dOld, 32'hDEAD_BEEF);
         end
      join
      readTxn(32'h4, 0, d, r);
      checkOutput("later_read_new", d, 32'hCAFE_F00D);

      writeTxn(32'h10, 32'h0BAD_0BAD, 4'hF, 0, 0, -1, r, lat);
      @(posedge clk); #1;
      checkOutput("pending_bvalid", 32'(bvalid), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("abort_bvalid", 32'(bvalid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      readTxn(32'h4, 0, d, r);
      checkOutput("abort_reg_cleared", d, 32'h0);
      readTxn(32'h10, 0, d, r);
      checkOutput("abort_no_partial", d, 32'h0);

      applyStimulus(60);
      repeat (4) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
